disp_chan_scheduler: RTL and testbench
======================================

Name: disp_chan_scheduler

Overview:
- Controller in front of the 8-channel 32-bit display multiplexer (Multi_8CH32).
- Sequences the multiplexer's channel select (Test) in manual, step or auto-rotate mode, and generates its single-cycle EN load pulse.
- Time-multiplexes the selected Disp_num, point_out and LE_out onto an 8-digit common-anode 7-segment display.

Parameters:
SCAN_DIV, 16, clk cycles per digit slot (>=2; use 2^17 on board).
DWELL, 4, full scan frames per channel in auto mode (>=1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sw_test  in  3  manual channel select
auto_en  in  1  1 = auto-rotate channels
step  in  1  single-cycle pulse: advance channel by one
load_req  in  1  level request to load Data0 into the mux
Disp_num  in  32  selected channel data from mux
point_out  in  8  per-digit decimal point from mux (1 = lit)
LE_out  in  8  per-digit blank from mux (1 = blank)
Test  out  3  channel select to mux
EN  out  1  load pulse to mux
AN  out  8  digit enables, active-low
SEG  out  8  segments, active-low; bit7 = dp, bits6:0 = g..a

Behaviour:
- Reset values (rst=0, asynchronous): Test=0, EN=0, AN=8'hFF, SEG=8'hFF; prescaler, digit, frame counters = 0; scan FSM = SCAN; channel FSM = MANUAL; ld_busy = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick asserts when the count equals SCAN_DIV-1.
  - At tick, digit advances 0..7 and wraps 7->0.
  - A 7->0 wrap is the frame end.
- Scan FSM:
  - SCAN: on the cycle after the digit counter updates (1-cycle registered latency), AN=~(8'b1<<digit).
  - SCAN, SEG[6:0]:
    - if LE_out[digit]=1, SEG=8'hFF;
    - otherwise SEG[6:0] = hex decode of Disp_num[4*digit+:4] and SEG[7] = ~point_out[digit].
  - BLANK: entered in the cycle Test changes value. AN=8'hFF and SEG=8'hFF for the remainder of the current slot plus the next full slot, then return to SCAN.
  - A Test change during BLANK restarts the BLANK period.
- Channel FSM:
  - MANUAL (auto_en=0): Test<=sw_test every cycle. A step pulse is ignored.
  - AUTO (auto_en=1): Test increments mod 8 (7->0) at every DWELL-th frame end; the frame counter then clears. A step pulse also increments Test and clears the frame counter.
  - Step pulse and dwell expiry in the same cycle: increment by exactly one.
  - MANUAL->AUTO: Test retains its value; the frame counter clears.
  - AUTO->MANUAL: Test takes sw_test on the next cycle; a value change triggers BLANK.
- Load handshake:
  - On the first cycle load_req=1 with ld_busy=0: EN=1 for exactly one cycle and ld_busy<=1.
  - ld_busy clears when load_req=0.
  - Holding load_req high produces no further pulses.
  - EN is independent of the scan and channel FSMs.
- Reset mid-operation forces all reset values immediately. Scanning resumes at digit 0 after rst is released.
- Widths:
  - digit 3b; frame counter $clog2(DWELL+1)b; prescaler $clog2(SCAN_DIV)b.
  - All arithmetic is unsigned with wrap-around.

Decomposition:
- Shared package (disp_pkg): SEG_BLANK=8'hFF, AN_OFF=8'hFF, scan-state encodings (SCAN, BLANK) and channel-mode encodings (MANUAL, AUTO).
- One sub-module, hex2seg: combinational 4-bit to 7-segment active-low decoder (0->7'h40, F->7'h0E).
- Both FSMs, the counters and the load handshake live in disp_chan_scheduler.

Test Plan:
1. Reset with SCAN_DIV=4, auto_en=0, sw_test=3, Disp_num=32'h76543210, point_out=0, LE_out=0.
   -> After release, Test=3.
   -> AN steps FE,FD,FB,...,7F, one step every 4 cycles.
   -> Digit 0 SEG=8'hC0; digit 1 SEG=8'hF9.
2. LE_out=8'h0F, point_out=8'h80.
   -> Digits 0-3: SEG=8'hFF.
   -> Digit 7 shows '7' with dp: SEG=8'h78.
3. auto_en=1, DWELL=2, starting at Test=6.
   -> Test goes 6->7 after 2 frames (64 cycles), then 7->0.
   -> Each change is followed by AN=8'hFF for at least one full slot.
4. In AUTO, pulse step in the same cycle as dwell expiry.
   -> Test increments by exactly 1; the next change comes a full DWELL later.
5. Hold load_req high for 10 cycles, drop it, then raise it again.
   -> EN=1 for exactly one cycle per rising request: two pulses in total.
6. Assert rst mid-slot with Test=5 in AUTO mode.
   -> AN=8'hFF, SEG=8'hFF, Test=0 and EN=0 asynchronously.
   -> After release, scanning restarts at AN=8'hFE in MANUAL mode following sw_test.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and state encodings for the display channel scheduler.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package disp_pkg;

  // Both display buses are active-low, so all-ones means dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } chan_mode_t;

  // One-cold anode enable for a digit position.
  function automatic logic [7:0] an_sel(input logic [2:0] digit);
    return ~(8'b0000_0001 << digit);
  endfunction

endpackage

// File: rtl/disp_chan_scheduler_if.sv
// Bundle between the scheduler, the 8-channel mux and the 7-segment display.
// Latency: n/a (wires only).
// Backpressure: none; EN is a one-shot pulse, everything else is level.
// Ports: sw_test/auto_en/step/load_req are user controls, Disp_num/point_out/
// LE_out come from the mux, Test/EN go to the mux, AN/SEG drive the display.
interface disp_chan_scheduler_if;
  logic [2:0]  sw_test;
  logic        auto_en;
  logic        step;
  logic        load_req;
  logic [31:0] Disp_num;
  logic [7:0]  point_out;
  logic [7:0]  LE_out;
  logic [2:0]  Test;
  logic        EN;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  // slave: the scheduler itself
  modport slave (
    input  sw_test, auto_en, step, load_req, Disp_num, point_out, LE_out,
    output Test, EN, AN, SEG
  );

  // master: whatever drives the controls and consumes the display outputs
  modport master (
    output sw_test, auto_en, step, load_req, Disp_num, point_out, LE_out,
    input  Test, EN, AN, SEG
  );
endinterface

// File: rtl/hex2seg.sv
// Hex nibble to active-low 7-segment pattern (bit order g..a).
// Latency: combinational.
// Backpressure: none.
// Ports: hex_i = nibble, seg_o = segments g..a, 0 = lit.
module hex2seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/disp_chan_scheduler.sv
// Channel sequencer + EN load pulse for Multi_8CH32, and 8-digit display scanner.
// Latency: AN/SEG 1 cycle after the digit counter moves; Test 1 cycle; EN 1 cycle after load_req rises.
// Backpressure: none; load_req is edge-detected, holding it high gives one pulse only.
// Ports: clk, rst (async active-low), bus (slave side of disp_chan_scheduler_if).
module disp_chan_scheduler
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 16,  // clk cycles per digit slot, >= 2
  parameter int DWELL    = 4    // full frames per channel in auto mode, >= 1
) (
  input logic                   clk,
  input logic                   rst,
  disp_chan_scheduler_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(DWELL + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(DWELL - 1);

  // ---------------- prescaler and digit counter ----------------
  logic [PW-1:0] pre_q;
  logic [2:0]    digit_q;
  logic          tick;
  logic          frame_end;

  assign tick      = (pre_q == PRE_LAST);
  assign frame_end = tick && (digit_q == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      digit_q <= '0;
    end else if (tick) begin
      pre_q   <= '0;
      digit_q <= digit_q + 3'd1;
    end else begin
      pre_q   <= pre_q + PW'(1);
    end
  end

  // ---------------- channel FSM ----------------
  chan_mode_t    mode_q,  mode_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [2:0]    test_q,  test_d;
  logic          dwell_done;
  logic          test_chg;

  assign dwell_done = frame_end && (frame_q == FRM_LAST);

  always_comb begin
    mode_d  = mode_q;
    frame_d = frame_q;
    test_d  = test_q;
    case (mode_q)
      MANUAL: begin
        if (bus.auto_en) begin
          // Keep the channel on entry; the dwell starts counting afresh.
          mode_d  = AUTO;
          frame_d = '0;
        end else begin
          test_d  = bus.sw_test;
        end
      end
      AUTO: begin
        if (!bus.auto_en) begin
          mode_d = MANUAL;
          test_d = bus.sw_test;
        end else if (bus.step || dwell_done) begin
          // A step coinciding with dwell expiry still advances only once.
          test_d  = test_q + 3'd1;
          frame_d = '0;
        end else if (frame_end) begin
          frame_d = frame_q + FW'(1);
        end
      end
      default: mode_d = MANUAL;
    endcase
  end

  // Scan FSM must see the change on the same edge Test updates.
  assign test_chg = (test_d != test_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MANUAL;
      frame_q <= '0;
      test_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      frame_q <= frame_d;
      test_q  <= test_d;
    end
  end

  // ---------------- scan FSM ----------------
  scan_state_t scan_q;
  logic        blank_half_q;  // first slot boundary inside BLANK already passed
  logic [7:0]  an_q;
  logic [7:0]  seg_q;
  logic [3:0]  nib;
  logic [6:0]  seg7;
  logic [7:0]  seg_d;

  assign nib = bus.Disp_num[{digit_q, 2'b00} +: 4];

  hex2seg u_hex2seg (
    .hex_i (nib),
    .seg_o (seg7)
  );

  assign seg_d = bus.LE_out[digit_q] ? SEG_BLANK : {~bus.point_out[digit_q], seg7};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q       <= SCAN;
      blank_half_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
    end else begin
      case (scan_q)
        SCAN: begin
          if (test_chg) begin
            scan_q       <= BLANK;
            blank_half_q <= 1'b0;
          end
        end
        BLANK: begin
          // Dark until the second slot boundary: rest of this slot plus one full slot.
          if (test_chg) begin
            blank_half_q <= 1'b0;
          end else if (tick) begin
            if (blank_half_q) begin
              scan_q       <= SCAN;
              blank_half_q <= 1'b0;
            end else begin
              blank_half_q <= 1'b1;
            end
          end
        end
        default: scan_q <= SCAN;
      endcase

      if (test_chg || scan_q == BLANK) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_BLANK;
      end else begin
        an_q  <= an_sel(digit_q);
        seg_q <= seg_d;
      end
    end
  end

  // ---------------- load handshake ----------------
  logic ld_busy_q;
  logic en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_busy_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      en_q      <= bus.load_req && !ld_busy_q;
      ld_busy_q <= bus.load_req;
    end
  end

  assign bus.Test = test_q;
  assign bus.EN   = en_q;
  assign bus.AN   = an_q;
  assign bus.SEG  = seg_q;

endmodule

// File: tb/tb_disp_chan_scheduler.sv
// Self-checking bench for disp_chan_scheduler with SCAN_DIV=4, DWELL=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_disp_chan_scheduler;

  localparam int SD = 4;
  localparam int DW = 2;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_chan_scheduler_if bus();

  disp_chan_scheduler #(.SCAN_DIV(SD), .DWELL(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int en_seen = 0;

  // Reference model: time counted in edges since reset release.
  int         m_cyc;
  int         m_blank_end;
  int         m_frames;
  logic [2:0] m_test;
  bit         m_auto;
  bit         m_prev_load;

  logic [2:0] exp_test;
  logic       exp_en;
  logic [7:0] exp_an;
  logic [7:0] exp_seg;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc       = 0;
    m_blank_end = -1;
    m_frames    = 0;
    m_test      = 3'd0;
    m_auto      = 1'b0;
    m_prev_load = 1'b0;
  endtask

  // Predict the outputs visible after the edge that just happened.
  task automatic model_step();
    int k;
    int d;
    bit fe;
    logic [2:0] old;
    logic [3:0] nib;
    m_cyc++;
    k   = m_cyc;
    fe  = (k % FRAME) == 0;
    d   = ((k - 1) / SD) % 8;
    old = m_test;
    if (!m_auto) begin
      if (bus.auto_en) begin
        m_auto   = 1'b1;
        m_frames = 0;
      end else begin
        m_test = bus.sw_test;
      end
    end else if (!bus.auto_en) begin
      m_auto = 1'b0;
      m_test = bus.sw_test;
    end else begin
      if (fe) m_frames++;
      if (bus.step || m_frames == DW) begin
        m_test   = 3'(m_test + 3'd1);
        m_frames = 0;
      end
    end
    // Dark through the second slot boundary after the change.
    if (m_test != old) m_blank_end = (k / SD + 2) * SD;
    exp_test    = m_test;
    exp_en      = bus.load_req && !m_prev_load;
    m_prev_load = bus.load_req;
    if (k <= m_blank_end) begin
      exp_an  = 8'hFF;
      exp_seg = 8'hFF;
    end else begin
      exp_an  = ~(8'h01 << d);
      nib     = bus.Disp_num[d*4 +: 4];
      exp_seg = bus.LE_out[d] ? 8'hFF : {~bus.point_out[d], hex_tab[nib]};
    end
  endtask

  task automatic step_cyc();
    @(posedge clk);
    model_step();
    #1;
    if (bus.EN) en_seen++;
    check("Test", {29'd0, bus.Test}, {29'd0, exp_test});
    check("EN",   {31'd0, bus.EN},   {31'd0, exp_en});
    check("AN",   {24'd0, bus.AN},   {24'd0, exp_an});
    check("SEG",  {24'd0, bus.SEG},  {24'd0, exp_seg});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_Test"}, {29'd0, bus.Test}, 32'd0);
    check({tag, "_EN"},   {31'd0, bus.EN},   32'd0);
    check({tag, "_AN"},   {24'd0, bus.AN},   32'hFF);
    check({tag, "_SEG"},  {24'd0, bus.SEG},  32'hFF);
  endtask

  initial begin
    logic [2:0] t0;
    int guard;

    // ---- reset with the manual-mode setup ----
    rst           = 1'b0;
    bus.sw_test   = 3'd3;
    bus.auto_en   = 1'b0;
    bus.step      = 1'b0;
    bus.load_req  = 1'b0;
    bus.Disp_num  = 32'h7654_3210;
    bus.point_out = 8'h00;
    bus.LE_out    = 8'h00;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Manual scan: initial Test change blanks, then AN walks FE..7F
    repeat (80) step_cyc();

    // Blanked low digits, decimal point on digit 7
    bus.LE_out    = 8'h0F;
    bus.point_out = 8'h80;
    repeat (40) step_cyc();

    // Random data and manual channel changes
    for (int i = 0; i < 6; i++) begin
      bus.Disp_num  = $urandom;
      bus.point_out = 8'($urandom);
      bus.LE_out    = 8'($urandom) & 8'($urandom);
      bus.sw_test   = 3'($urandom_range(0, 7));
      repeat (20) step_cyc();
    end

    // ---- auto rotate starting from channel 6; sw_test is ignored ----
    bus.LE_out  = 8'h00;
    bus.sw_test = 3'd6;
    repeat (3) step_cyc();
    bus.auto_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.sw_test = 3'($urandom_range(0, 7));
      step_cyc();
    end

    // ---- step pulse landing on the dwell-expiry edge ----
    guard = 0;
    while (!(((m_cyc + 1) % FRAME) == 0 && m_frames == DW - 1) && guard < 500) begin
      step_cyc();
      guard++;
    end
    check("dwell_sync_found", {31'd0, guard < 500}, 32'd1);
    t0       = m_test;
    bus.step = 1'b1;
    step_cyc();
    bus.step = 1'b0;
    check("step_at_dwell", {29'd0, bus.Test}, {29'd0, 3'(t0 + 3'd1)});
    repeat (DW * FRAME - 1) step_cyc();
    check("dwell_hold", {29'd0, bus.Test}, {29'd0, 3'(t0 + 3'd1)});
    step_cyc();
    check("dwell_next", {29'd0, bus.Test}, {29'd0, 3'(t0 + 3'd2)});

    // Random step pulses with random data
    for (int i = 0; i < 150; i++) begin
      bus.step = ($urandom_range(0, 15) == 0);
      if (i % 30 == 0) bus.Disp_num = $urandom;
      step_cyc();
    end
    bus.step = 1'b0;

    // ---- AUTO -> MANUAL picks up sw_test, then back to AUTO ----
    bus.sw_test = 3'(m_test + 3'd3);
    bus.auto_en = 1'b0;
    repeat (40) step_cyc();
    bus.auto_en = 1'b1;
    repeat (20) step_cyc();

    // ---- load handshake: two rising requests, two pulses ----
    en_seen      = 0;
    bus.load_req = 1'b1;
    repeat (10) step_cyc();
    bus.load_req = 1'b0;
    repeat (3) step_cyc();
    bus.load_req = 1'b1;
    repeat (5) step_cyc();
    bus.load_req = 1'b0;
    repeat (3) step_cyc();
    check("en_pulses", en_seen, 32'd2);

    for (int i = 0; i < 60; i++) begin
      bus.load_req = 1'($urandom_range(0, 1));
      step_cyc();
    end
    bus.load_req = 1'b0;

    // ---- reset mid-slot on channel 5 in AUTO with EN high ----
    guard = 0;
    while (m_test != 3'd5 && guard < 20) begin
      bus.step = 1'b1;
      step_cyc();
      bus.step = 1'b0;
      step_cyc();
      guard++;
    end
    check("reach_ch5", {29'd0, m_test}, 32'd5);
    bus.load_req = 1'b1;
    step_cyc();
    #3;
    rst          = 1'b0;
    bus.auto_en  = 1'b0;
    bus.sw_test  = 3'd0;
    bus.load_req = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    rst = 1'b1;
    step_cyc();
    check("resume_an", {24'd0, bus.AN}, 32'hFE);
    for (int i = 0; i < 60; i++) begin
      if (i % 15 == 14) bus.sw_test = 3'($urandom_range(0, 7));
      step_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
